uart16_rx: RTL and testbench

Serial receiver that pairs with the team's 16-bit UART transmitter: it samples an asynchronous 8N1 line, recovers bytes, and assembles two consecutive bytes (high byte first) into a 16-bit word. It sits at the FPGA pin boundary, behind `uart_rx`, and feeds parallel words to the fabric. A valid pulse marks each word, and a flag marks framing errors.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 120 ++++++++++++
 rtl/uart16_rx.sv | 107 ++++++++++
 tb/tb_uart16_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 16-bit UART receiver.
// UART16_RX_PARITY_EN selects the 11-bit even-parity frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } byte_state_e;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_e;

  localparam int DATA_BITS = 8;
`ifdef UART16_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: line synchronizer, bit-timer and byte FSM (8N1, or 8E1 with
// UART16_RX_PARITY_EN). All bit samples are taken at mid-bit.
//
// state  | meaning
// IDLE   | waiting for a synchronized falling edge
// START  | timing to mid start bit, rejects false starts
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking even parity (parity build only)
// STOP   | checking the stop bit, delivering or rejecting the byte
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error,
  output logic       active
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic          sync1_q, sync2_q, prev_q;
  byte_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          line, fall;

  assign line = sync2_q;
  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 1'b1;
    shift_d    = shift_q;
    bit_d      = bit_q;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART16_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART16_RX_PARITY_EN
      PARITY: begin
        if (timer_q == FULL_M1) begin
          timer_d = '0;
          if ((^shift_q) != line) begin
            byte_error = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
        if (timer_q == FULL_M1) begin
          byte_valid = line;
          byte_error = ~line;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign active    = (state_q != IDLE);

endmodule

// File: rtl/uart16_rx.sv
// 16-bit UART receiver: pairs consecutive bytes (high first) into a word and
// flags framing/parity errors and inter-byte timeouts. Option: UART16_RX_PARITY_EN.
module uart16_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_in,
  output logic [15:0] dataout,
  output logic        dataout_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW      = $clog2(TO_LIMIT + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TO_LIMIT);

  logic [7:0]     byte_data;
  logic           byte_valid, byte_error, byte_active;

  asm_state_e     asm_q, asm_d;
  logic [7:0]     hi_q, hi_d;
  logic [TOW-1:0] to_q, to_d;
  logic [15:0]    dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           busy_q, busy_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_error(byte_error),
    .active    (byte_active)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_q   <= WAIT_HI;
      hi_q    <= '0;
      to_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      hi_q    <= hi_d;
      to_q    <= to_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    asm_d   = asm_q;
    hi_d    = hi_q;
    to_d    = to_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (byte_error) begin
      ferr_d = 1'b1;
      asm_d  = WAIT_HI;
      hi_d   = '0;
    end else if (byte_valid) begin
      // A good low byte takes priority over a timeout landing in the same cycle.
      if (asm_q == WAIT_HI) begin
        hi_d  = byte_data;
        to_d  = '0;
        asm_d = WAIT_LO;
      end else begin
        dout_d  = {hi_q, byte_data};
        valid_d = 1'b1;
        asm_d   = WAIT_HI;
      end
    end else if (asm_q == WAIT_LO) begin
      if (to_q == TO_MAX) begin
        ferr_d = 1'b1;
        asm_d  = WAIT_HI;
        hi_d   = '0;
      end else if (byte_active) begin
        // Only the idle gap between bytes counts toward the timeout.
        to_d = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    busy_d = byte_active | (asm_d == WAIT_LO);
  end

  assign dataout       = dout_q;
  assign dataout_valid = valid_q;
  assign frame_error   = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart16_rx.sv
// Scoreboard bench for uart16_rx at CLKS_PER_BIT=16, TIMEOUT_BITS=4.
module tb_uart16_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int TOB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        serial_in = 1'b1;
  logic [15:0] dataout;
  logic        dataout_valid, frame_error, busy;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int valid_seen = 0;
  int err_base;
  logic [15:0] exp_q[$];

  uart16_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .dataout      (dataout),
    .dataout_valid(dataout_valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (dataout_valid) begin
        valid_seen++;
        if (exp_q.size() == 0) check_eq("unexpected_word", {16'h0, dataout}, 32'h1_0000);
        else check_eq("word", {16'h0, dataout}, {16'h0, exp_q.pop_front()});
      end
      if (frame_error) err_seen++;
    end
  end

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * CPB) @(negedge clock);
  endtask

  // Sends one frame; cut_at >= 0 asserts reset halfway through that frame bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_b = 1'b1,
                           input logic bad_par = 1'b0, input int cut_at = -1);
    logic frame[0:10];
    int   n;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = b[i];
    n = 9;
`ifdef UART16_RX_PARITY_EN
    frame[n] = (^b) ^ bad_par;
    n++;
`endif
    frame[n] = stop_b;
    n++;
    for (int i = 0; i < n; i++) begin
      serial_in = frame[i];
      if (i == cut_at) begin
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_dataout", {16'h0, dataout}, 32'h0);
        check_eq("rst_valid", {31'h0, dataout_valid}, 32'h0);
        check_eq("rst_ferr", {31'h0, frame_error}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        serial_in = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic wait_not_busy(input string tag, input int max_cycles);
    for (int k = 0; k < max_cycles && busy; k++) @(negedge clock);
    check_eq(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic end_scenario(input string tag, input int exp_errs);
    check_eq({tag, "_errs"}, err_seen - err_base, exp_errs);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    err_base = err_seen;
  endtask

  initial begin
    int exp_words;
    exp_words = 6;
    repeat (3) @(negedge clock);
    check_eq("reset_dataout", {16'h0, dataout}, 32'h0);
    check_eq("reset_valid", {31'h0, dataout_valid}, 32'h0);
    check_eq("reset_ferr", {31'h0, frame_error}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    idle_bits(2);
    err_base = err_seen;

    exp_q.push_back(16'hFFAA);
    send_byte(8'hFF);
    send_byte(8'hAA);
    idle_bits(2);
    end_scenario("ffaa", 0);

    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    idle_bits(2);
    end_scenario("four_bytes", 0);

    serial_in = 1'b0;
    repeat (5) @(negedge clock);
    serial_in = 1'b1;
    check_eq("glitch_busy_rise", {31'h0, busy}, 32'h1);
    wait_not_busy("glitch_busy_fall", 8);
    idle_bits(2);
    end_scenario("glitch", 0);

    exp_q.push_back(16'hABCD);
    send_byte(8'h55, 1'b0);
    idle_bits(1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    idle_bits(2);
    end_scenario("bad_stop", 1);

    send_byte(8'h11);
    check_eq("timeout_busy", {31'h0, busy}, 32'h1);
    idle_bits(5);
    check_eq("timeout_err", err_seen - err_base, 1);
    wait_not_busy("timeout_idle", 4);
    exp_q.push_back(16'h2233);
    send_byte(8'h22);
    send_byte(8'h33);
    idle_bits(2);
    end_scenario("timeout", 1);

    send_byte(8'hBE);
    send_byte(8'hEF, 1'b1, 1'b0, 4);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    idle_bits(2);
    exp_q.push_back(16'hCAFE);
    send_byte(8'hCA);
    send_byte(8'hFE);
    idle_bits(2);
    end_scenario("mid_reset", 0);

    serial_in = 1'b0;
    repeat (12 * CPB) @(negedge clock);
    check_eq("break_idle", {31'h0, busy}, 32'h0);
    serial_in = 1'b1;
    idle_bits(2);
    end_scenario("break", 1);

`ifdef UART16_RX_PARITY_EN
    exp_words = 7;
    exp_q.push_back(16'h0708);
    send_byte(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check_eq("parity_err", err_seen - err_base, 1);
    send_byte(8'h07);
    send_byte(8'h08);
    idle_bits(2);
    end_scenario("parity", 1);
`endif

    check_eq("word_count", valid_seen, exp_words);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
